alpha_aggregator: RTL and testbench
===================================

Name: alpha_aggregator

Overview:
- Aggregation stage directly downstream of the softmax. Consumes one subgraph at a time as a stream of (alpha, WH row) beats.
- For each feature f it computes new_feature[f] = sum over neighbours j of alpha_j * WH_j[f].
- Emits one packed feature vector per subgraph toward the new-feature BRAM writer.

Parameters:
- NUM_FEATURE_OUT, 16, features per WH row and per output vector
- WH_W, 16, signed width of one WH element
- ALPHA_W, 16, unsigned alpha width, format Q(ALPHA_W-ALPHA_FRAC).ALPHA_FRAC
- ALPHA_FRAC, 14, alpha fractional bits
- NUM_NODE_WIDTH, 8, width of the per-subgraph node count
- ACC_W, WH_W+ALPHA_W+NUM_NODE_WIDTH, signed accumulator width
- OUT_W, 16, signed width of one output element

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (asserted = 1, sampled on rising clk)
- aggr_valid_i  in  1  input beat valid
- aggr_ready_o  out  1  block accepts a beat this cycle
- alpha_i  in  ALPHA_W  softmax coefficient for this neighbour
- wh_row_i  in  NUM_FEATURE_OUT*WH_W  packed WH row of this neighbour; element f is at [f*WH_W +: WH_W]
- num_nodes_i  in  NUM_NODE_WIDTH  subgraph node count, sampled on the first beat only
- new_feature_o  out  NUM_FEATURE_OUT*OUT_W  packed result vector
- new_feature_valid_o  out  1  result valid
- new_feature_ready_i  in  1  downstream accepts the result
- subgraph_cnt_o  out  32  number of subgraphs completed
- len_err_o  out  1  sticky error: a subgraph with num_nodes_i = 0 was received

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - FSM to IDLE; accumulators cleared.
  - aggr_ready_o=0, new_feature_valid_o=0, new_feature_o=0, subgraph_cnt_o=0, len_err_o=0.
  - Reset mid-subgraph discards all partial sums; no output is produced for that subgraph.
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - aggr_ready_o=1 from the first cycle after reset is released.
  - On a handshake (valid & ready), latch num_nodes_i into remaining and go to ACCUM. The beat is consumed as node 1.
  - If num_nodes_i = 0: treat it as 1, set len_err_o, continue normally.
- ACCUM:
  - aggr_ready_o=1; every handshake consumes one node.
  - After the handshake that consumes node N (N = latched count), deassert aggr_ready_o and go to DRAIN.
  - A single-node subgraph goes IDLE -> DRAIN directly.
- Pipeline:
  - Stage 1 registers the NUM_FEATURE_OUT products alpha (zero-extended, signed) * WH[f], each signed WH_W+ALPHA_W+1 bits.
  - Stage 2 adds each product into its sign-extended ACC_W accumulator.
  - Full throughput: one beat per cycle while valid is held.
- DRAIN:
  - Waits for the stage-1 product of the last beat to land in the accumulator. This takes 2 cycles after the last handshake.
  - Then goes to OUT.
- OUT (output arithmetic, per element):
  - r = (acc + 2^(ALPHA_FRAC-1)) >>> ALPHA_FRAC, i.e. round-half-up, arithmetic shift.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the results into new_feature_o and assert new_feature_valid_o.
- Latency: 3 cycles from the last input handshake to new_feature_valid_o=1.
- Output handshake:
  - new_feature_o and new_feature_valid_o hold stable until new_feature_ready_i=1.
  - On the handshake: valid drops next cycle, accumulators clear, subgraph_cnt_o increments (32-bit wrap), and the FSM returns to IDLE.
  - aggr_ready_o=1 the cycle after the output handshake.
- Back-pressure: input is not accepted in DRAIN or OUT. At most one subgraph is in flight.
- aggr_valid_i may drop between beats in ACCUM; the FSM simply waits. There is no timeout.
- Signals num_nodes_i and alpha_i/wh_row_i are ignored whenever no handshake occurs.
- Simultaneous events: if the output handshake and rst_n=1 occur in the same cycle, reset wins and subgraph_cnt_o becomes 0.

Test Plan:
- Identity: N=1, alpha=16384 (1.0), wh_row element f = f-8 -> new_feature_o[f] = f-8, valid 3 cycles after the handshake, subgraph_cnt_o=1.
- Average: N=2, alpha=8192 (0.5) each, rows all 100 then all -40 -> every element = 30.
- Rounding: N=1, alpha=8192, wh=3 -> 2 (1.5 rounds up); wh=-3 -> -1 (-1.5 rounds up).
- Saturation: N=4, alpha=16384, wh=32767 on all -> every element = 32767. Same with wh=-32768 -> -32768.
- Back-pressure: hold new_feature_ready_i=0 for 10 cycles -> output stable and aggr_ready_o=0 throughout. Release -> one transfer, aggr_ready_o=1 next cycle. Gappy aggr_valid_i (N=3, one-cycle gaps) gives the same sum as back-to-back.
- Errors and reset: num_nodes_i=0 with alpha=16384, wh=7 -> len_err_o=1 stays high, output element = 7. Reset after 2 of 5 beats -> all outputs 0, no valid. The next N=1 subgraph is correct and subgraph_cnt_o=1.

Source files
------------

// File: rtl/alpha_aggregator_if.sv
// Stream interface of the alpha aggregator.
// Input side: (alpha, WH row) beats. Output side: one packed feature vector per subgraph.
interface alpha_aggregator_if #(
    parameter int NUM_FEATURE_OUT = 16,
    parameter int WH_W            = 16,
    parameter int ALPHA_W         = 16,
    parameter int NUM_NODE_WIDTH  = 8,
    parameter int OUT_W           = 16
);
    logic                              aggr_valid_i;
    logic                              aggr_ready_o;
    logic [ALPHA_W-1:0]                alpha_i;
    logic [NUM_FEATURE_OUT*WH_W-1:0]   wh_row_i;
    logic [NUM_NODE_WIDTH-1:0]         num_nodes_i;
    logic [NUM_FEATURE_OUT*OUT_W-1:0]  new_feature_o;
    logic                              new_feature_valid_o;
    logic                              new_feature_ready_i;

    // Aggregator side
    modport slave (
        input  aggr_valid_i, alpha_i, wh_row_i, num_nodes_i, new_feature_ready_i,
        output aggr_ready_o, new_feature_o, new_feature_valid_o
    );

    // Producer / consumer side
    modport master (
        output aggr_valid_i, alpha_i, wh_row_i, num_nodes_i, new_feature_ready_i,
        input  aggr_ready_o, new_feature_o, new_feature_valid_o
    );
endinterface

// File: rtl/alpha_aggregator.sv
// Alpha aggregator: for every feature f, accumulates alpha_j * WH_j[f] over the
// neighbours of one subgraph, then rounds, saturates and emits the vector.
module alpha_aggregator #(
    parameter int NUM_FEATURE_OUT = 16,
    parameter int WH_W            = 16,
    parameter int ALPHA_W         = 16,
    parameter int ALPHA_FRAC      = 14,
    parameter int NUM_NODE_WIDTH  = 8,
    parameter int ACC_W           = WH_W + ALPHA_W + NUM_NODE_WIDTH,
    parameter int OUT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,   // active-high synchronous reset despite the name
    alpha_aggregator_if.slave    bus,
    output logic [31:0]          subgraph_cnt_o,
    output logic                 len_err_o
);
    localparam int PROD_W = WH_W + ALPHA_W + 1;
    // One guard bit so the rounding bias can never wrap the accumulator value.
    localparam int RND_W  = ACC_W + 1;
    localparam logic signed [RND_W-1:0] ROUND_BIAS = RND_W'(2 ** (ALPHA_FRAC - 1));
    localparam logic signed [RND_W-1:0] OUT_MAX    = RND_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN    = ~OUT_MAX;
    localparam logic [NUM_NODE_WIDTH-1:0] ONE_NODE = NUM_NODE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t                    state_reg, state_next;
    logic [NUM_NODE_WIDTH-1:0] remaining_reg, remaining_next;
    logic                      drain_cnt_reg, drain_cnt_next;
    logic                      valid_reg;
    logic [31:0]               cnt_reg;
    logic                      err_reg;
    logic                      p_valid_reg;

    logic                      in_fire;
    logic                      out_load;
    logic                      out_fire;
    logic signed [ALPHA_W:0]   alpha_ext;
    logic [NUM_FEATURE_OUT*OUT_W-1:0] out_packed;

    // Ready is held low while reset is asserted, then follows the accepting states.
    assign bus.aggr_ready_o = !rst_n && ((state_reg == IDLE) || (state_reg == ACCUM));
    assign in_fire   = bus.aggr_valid_i && bus.aggr_ready_o;
    assign out_load  = (state_reg == OUT) && !valid_reg;
    assign out_fire  = (state_reg == OUT) && valid_reg && bus.new_feature_ready_i;
    assign alpha_ext = {1'b0, bus.alpha_i};

    assign bus.new_feature_o       = out_packed;
    assign bus.new_feature_valid_o = valid_reg;
    assign subgraph_cnt_o          = cnt_reg;
    assign len_err_o               = err_reg;

    // Next-state logic: node counting, two-cycle drain of the product pipeline, output hold.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    // A zero count is handled as a single-node subgraph.
                    if (bus.num_nodes_i <= ONE_NODE) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 1'b0;
                    end else begin
                        remaining_next = bus.num_nodes_i - ONE_NODE;
                        state_next     = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    remaining_next = remaining_reg - ONE_NODE;
                    if (remaining_reg == ONE_NODE) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_reg) begin
                    state_next = OUT;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end
            OUT: begin
                if (out_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: FSM state, output valid, completed-subgraph counter, sticky length error.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            drain_cnt_reg <= 1'b0;
            valid_reg     <= 1'b0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            p_valid_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            drain_cnt_reg <= drain_cnt_next;
            p_valid_reg   <= in_fire;
            if (out_load) begin
                valid_reg <= 1'b1;
            end else if (out_fire) begin
                valid_reg <= 1'b0;
            end
            if (out_fire) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
            if (in_fire && (state_reg == IDLE) && (bus.num_nodes_i == '0)) begin
                err_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_FEATURE_OUT; gi++) begin : g_lane
            logic signed [WH_W-1:0]   wh_elem;
            logic signed [PROD_W-1:0] prod_reg;
            logic signed [ACC_W-1:0]  acc_reg;
            logic signed [OUT_W-1:0]  out_reg;
            logic signed [RND_W-1:0]  rounded;
            logic signed [RND_W-1:0]  shifted;
            logic signed [OUT_W-1:0]  sat_val;

            assign wh_elem = bus.wh_row_i[gi*WH_W +: WH_W];
            assign rounded = RND_W'(acc_reg) + ROUND_BIAS;
            assign shifted = rounded >>> ALPHA_FRAC;
            assign out_packed[gi*OUT_W +: OUT_W] = out_reg;

            // Round-half-up result clamped into the signed output range.
            always_comb begin
                sat_val = shifted[OUT_W-1:0];
                if (shifted > OUT_MAX) begin
                    sat_val = OUT_MAX[OUT_W-1:0];
                end else if (shifted < OUT_MIN) begin
                    sat_val = OUT_MIN[OUT_W-1:0];
                end
            end

            // Per-feature datapath: product register, accumulator, output register.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    prod_reg <= '0;
                    acc_reg  <= '0;
                    out_reg  <= '0;
                end else begin
                    if (in_fire) begin
                        prod_reg <= alpha_ext * wh_elem;
                    end
                    if (out_fire) begin
                        acc_reg <= '0;
                    end else if (p_valid_reg) begin
                        acc_reg <= acc_reg + ACC_W'(prod_reg);
                    end
                    if (out_load) begin
                        out_reg <= sat_val;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_alpha_aggregator.sv
// Directed testbench for alpha_aggregator with hand-computed expected vectors.
module tb_alpha_aggregator;
    localparam int NF = 16;
    localparam int WW = 16;
    localparam int AW = 16;
    localparam int NW = 8;
    localparam int OW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] subgraph_cnt;
    logic        len_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alpha_aggregator_if #(.NUM_FEATURE_OUT(NF), .WH_W(WW), .ALPHA_W(AW),
                          .NUM_NODE_WIDTH(NW), .OUT_W(OW)) bus();

    alpha_aggregator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .subgraph_cnt_o (subgraph_cnt),
        .len_err_o      (len_err)
    );

    function automatic logic [NF*WW-1:0] row_const(input int v);
        logic [NF*WW-1:0] r;
        for (int f = 0; f < NF; f++) r[f*WW +: WW] = v[WW-1:0];
        return r;
    endfunction

    function automatic logic [NF*WW-1:0] row_ramp(input int base);
        logic [NF*WW-1:0] r;
        int v;
        for (int f = 0; f < NF; f++) begin
            v = base + f;
            r[f*WW +: WW] = v[WW-1:0];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [AW-1:0] a, input logic [NF*WW-1:0] row, input logic [NW-1:0] n);
        bus.aggr_valid_i = 1'b1;
        bus.alpha_i      = a;
        bus.wh_row_i     = row;
        bus.num_nodes_i  = n;
        for (int t = 0; t < 20 && bus.aggr_ready_o !== 1'b1; t++) tick;
        if (bus.aggr_ready_o !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL beat_accept: aggr_ready_o=%b required 1 within 20 cycles", bus.aggr_ready_o);
        end
        tick;
        // Junk on the data lines outside a handshake must have no effect.
        bus.aggr_valid_i = 1'b0;
        bus.alpha_i      = '1;
        bus.wh_row_i     = row_const(12345);
        bus.num_nodes_i  = '0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.new_feature_valid_o !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        if (bus.new_feature_valid_o !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL result_timeout: new_feature_valid_o=%b required 1 within 20 cycles", bus.new_feature_valid_o);
        end
    endtask

    task automatic take_result;
        $display("xfer %0d: elem0=%0d elem15=%0d", exp_cnt + 1,
                 $signed(bus.new_feature_o[0 +: OW]), $signed(bus.new_feature_o[15*OW +: OW]));
        bus.new_feature_ready_i = 1'b1;
        tick;
        bus.new_feature_ready_i = 1'b0;
        exp_cnt++;
    endtask

    task automatic check_vec(input string name, input logic [NF*OW-1:0] exp);
        n_cmp++;
        if (bus.new_feature_o !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, bus.new_feature_o, exp);
        end
    endtask

    task automatic test_reset;
        bus.aggr_valid_i = 1'b0; bus.alpha_i = '0; bus.wh_row_i = '0;
        bus.num_nodes_i = '0; bus.new_feature_ready_i = 1'b0;
        rst_n = 1'b1;
        tick; tick; tick;
        n_cmp++; if (bus.aggr_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", bus.aggr_ready_o); end
        n_cmp++; if (bus.new_feature_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", bus.new_feature_valid_o); end
        n_cmp++; if (bus.new_feature_o !== '0) begin n_err++; $display("FAIL reset_out: got %h required 0", bus.new_feature_o); end
        n_cmp++; if (subgraph_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d required 0", subgraph_cnt); end
        n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b required 0", len_err); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.aggr_ready_o !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b required 1", bus.aggr_ready_o); end
        exp_cnt = 0;
    endtask

    task automatic test_identity;
        int lat;
        send_beat(16'd16384, row_ramp(-8), 8'd1);
        wait_result(lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL identity_latency: got %0d required 3", lat); end
        check_vec("identity_out", row_ramp(-8));
        take_result();
        n_cmp++; if (bus.new_feature_valid_o !== 1'b0) begin n_err++; $display("FAIL identity_valid_drop: got %b required 0", bus.new_feature_valid_o); end
        n_cmp++; if (bus.aggr_ready_o !== 1'b1) begin n_err++; $display("FAIL identity_ready: got %b required 1", bus.aggr_ready_o); end
        n_cmp++; if (subgraph_cnt !== 32'(exp_cnt)) begin n_err++; $display("FAIL identity_cnt: got %0d required %0d", subgraph_cnt, exp_cnt); end
    endtask

    task automatic test_average;
        int lat;
        send_beat(16'd8192, row_const(100), 8'd2);
        send_beat(16'd8192, row_const(-40), 8'd99);   // count ignored after first beat
        wait_result(lat);
        check_vec("average_out", row_const(30));
        take_result();
    endtask

    task automatic test_rounding;
        int lat;
        send_beat(16'd8192, row_const(3), 8'd1);
        wait_result(lat);
        check_vec("round_pos", row_const(2));
        take_result();
        send_beat(16'd8192, row_const(-3), 8'd1);
        wait_result(lat);
        check_vec("round_neg", row_const(-1));
        take_result();
    endtask

    task automatic test_saturation;
        int lat;
        for (int i = 0; i < 4; i++) send_beat(16'd16384, row_const(32767), 8'd4);
        wait_result(lat);
        check_vec("sat_pos", row_const(32767));
        take_result();
        for (int i = 0; i < 4; i++) send_beat(16'd16384, row_const(-32768), 8'd4);
        wait_result(lat);
        check_vec("sat_neg", row_const(-32768));
        take_result();
    endtask

    task automatic test_back_pressure;
        int lat;
        logic bad;
        send_beat(16'd16384, row_const(11), 8'd1);
        wait_result(lat);
        bad = 1'b0;
        bus.aggr_valid_i = 1'b1;   // offered beat must not be taken while the result is held
        for (int i = 0; i < 10; i++) begin
            if (bus.new_feature_valid_o !== 1'b1 || bus.new_feature_o !== row_const(11) ||
                bus.aggr_ready_o !== 1'b0) bad = 1'b1;
            tick;
        end
        bus.aggr_valid_i = 1'b0;
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL hold_stable: got unstable=%b required 0", bad); end
        check_vec("hold_out", row_const(11));
        take_result();
        n_cmp++; if (bus.new_feature_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_single_xfer: got %b required 0", bus.new_feature_valid_o); end
        n_cmp++; if (bus.aggr_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_ready_after: got %b required 1", bus.aggr_ready_o); end
        n_cmp++; if (subgraph_cnt !== 32'(exp_cnt)) begin n_err++; $display("FAIL hold_cnt: got %0d required %0d", subgraph_cnt, exp_cnt); end
    endtask

    task automatic test_gappy;
        int lat;
        send_beat(16'd16384, row_const(10), 8'd3);
        tick;
        send_beat(16'd16384, row_const(20), 8'd3);
        tick;
        send_beat(16'd16384, row_const(-5), 8'd3);
        wait_result(lat);
        check_vec("gappy_out", row_const(25));
        take_result();
        send_beat(16'd16384, row_const(10), 8'd3);
        send_beat(16'd16384, row_const(20), 8'd3);
        send_beat(16'd16384, row_const(-5), 8'd3);
        wait_result(lat);
        check_vec("b2b_out", row_const(25));
        take_result();
    endtask

    task automatic test_len_err;
        int lat;
        n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL len_err_pre: got %b required 0", len_err); end
        send_beat(16'd16384, row_const(7), 8'd0);
        wait_result(lat);
        check_vec("len_zero_out", row_const(7));
        n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL len_err_set: got %b required 1", len_err); end
        take_result();
        send_beat(16'd16384, row_const(1), 8'd1);
        wait_result(lat);
        take_result();
        n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL len_err_sticky: got %b required 1", len_err); end
    endtask

    task automatic test_mid_reset;
        int lat;
        logic seen;
        send_beat(16'd16384, row_const(50), 8'd5);
        send_beat(16'd16384, row_const(50), 8'd5);
        rst_n = 1'b1;
        tick;
        n_cmp++; if (bus.new_feature_o !== '0) begin n_err++; $display("FAIL midrst_out: got %h required 0", bus.new_feature_o); end
        n_cmp++; if (subgraph_cnt !== 32'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d required 0", subgraph_cnt); end
        n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b required 0", len_err); end
        rst_n = 1'b0;
        exp_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.new_feature_valid_o !== 1'b0) seen = 1'b1;
            tick;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_novalid: got valid_seen=%b required 0", seen); end
        send_beat(16'd16384, row_const(5), 8'd1);
        wait_result(lat);
        check_vec("midrst_next_out", row_const(5));
        take_result();
        n_cmp++; if (subgraph_cnt !== 32'd1) begin n_err++; $display("FAIL midrst_next_cnt: got %0d required 1", subgraph_cnt); end
    endtask

    task automatic test_reset_vs_handshake;
        int lat;
        send_beat(16'd16384, row_const(3), 8'd1);
        wait_result(lat);
        bus.new_feature_ready_i = 1'b1;
        rst_n = 1'b1;
        tick;
        bus.new_feature_ready_i = 1'b0;
        rst_n = 1'b0;
        exp_cnt = 0;
        n_cmp++; if (subgraph_cnt !== 32'd0) begin n_err++; $display("FAIL rst_wins_cnt: got %0d required 0", subgraph_cnt); end
        n_cmp++; if (bus.new_feature_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_wins_valid: got %b required 0", bus.new_feature_valid_o); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_average();
        test_rounding();
        test_saturation();
        test_back_pressure();
        test_gappy();
        test_len_err();
        test_mid_reset();
        test_reset_vs_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
